// File: rtl/kgp_risc_pkg.sv
// Shared KGP_RISC definitions: operand width, multiply/divide op encodings and
// the multiply/divide unit's FSM states.
package kgp_risc_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MULDIV_MULU = 2'b00,
    MULDIV_MUL  = 2'b01,
    MULDIV_DIVU = 2'b10,
    MULDIV_DIV  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } muldiv_state_e;

  // Two's-complement magnitude when the op is signed, raw value otherwise.
  function automatic logic [XLEN-1:0] op_mag(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide: radix-2 shift-add multiply or restoring
// divide over 32 cycles, with sign correction in a final fix-up cycle.
module muldiv_unit
  import kgp_risc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_hi_o,
  output logic [XLEN-1:0] result_lo_o,
  output logic            div_by_zero_o
);

  muldiv_state_e state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   raw_a_q, raw_a_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;
  logic              dbz_q, dbz_d;

  logic              in_div, in_signed, in_dz;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, prod_neg;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_sub, quot, rem;
  logic              borrow;

  assign in_div    = op_i[1];
  assign in_signed = op_i[0];
  assign in_dz     = in_div && (op_b_i == '0);
  assign mag_a     = op_mag(op_a_i, in_signed);
  assign mag_b     = op_mag(op_b_i, in_signed);

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

  // Divide: acc = {remainder, quotient}; the remainder after shifting needs 33 bits.
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign borrow   = rem_sh < {1'b0, b_q};
  assign rem_sub  = rem_sh[XLEN-1:0] - b_q;
  assign div_next = borrow ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                           : {rem_sub, acc_q[XLEN-2:0], 1'b1};

  assign prod_neg = ~acc_q + 1'b1;
  assign quot     = acc_q[XLEN-1:0];
  assign rem      = acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    b_d       = b_q;
    raw_a_d   = raw_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    dbz_d     = dbz_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          is_div_d  = in_div;
          acc_d     = {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
          b_d       = in_div ? mag_b : mag_a;
          raw_a_d   = op_a_i;
          neg_res_d = in_signed && (op_a_i[XLEN-1] ^ op_b_i[XLEN-1]);
          neg_rem_d = in_signed && in_div && op_a_i[XLEN-1];
          dz_d      = in_dz;
          cnt_d     = '0;
          state_d   = in_dz ? StFix : StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = StFix;
      end
      StFix: begin
        state_d = StDone;
        dbz_d   = dz_q;
        if (dz_q) begin
          hi_d = raw_a_q;
          lo_d = '1;
        end else if (!is_div_q) begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
        end else begin
          lo_d = neg_res_q ? (~quot + 1'b1) : quot;
          hi_d = neg_rem_q ? (~rem + 1'b1) : rem;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      b_q       <= '0;
      raw_a_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      raw_a_q   <= raw_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy_o        = (state_q == StRun) || (state_q == StFix);
  assign done_o        = (state_q == StDone);
  assign result_hi_o   = hi_q;
  assign result_lo_o   = lo_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, signed/unsigned
// results, divide-by-zero, ignored starts, back-to-back and mid-run reset.
module tb_muldiv_unit;

  logic        clk, rst, start;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic        busy, done, dbz;
  logic [31:0] res_hi, res_lo;
  int          errors = 0;
  int          checks = 0;

  muldiv_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .op_i         (op),
    .op_a_i       (opa),
    .op_b_i       (opb),
    .busy_o       (busy),
    .done_o       (done),
    .result_hi_o  (res_hi),
    .result_lo_o  (res_lo),
    .div_by_zero_o(dbz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Launches one op, scrambles inputs after the accept edge, returns the
  // number of edges from accept to done (-1 if done never came).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; opa = $urandom; opb = $urandom;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (res_hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", res_hi); end
    checks++; if (res_lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", res_lo); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", dbz); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mulu();
    int lat;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL mulu_latency: got %0d want 33", lat); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mulu_busy_in_done: got %b want 0", busy); end
    checks++; if (res_hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulu_hi: got %h want fffffffe", res_hi); end
    checks++; if (res_lo !== 32'h0000_0001) begin errors++; $display("FAIL mulu_lo: got %h want 00000001", res_lo); end
  endtask

  task automatic test_signed();
    int lat;
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, lat);
    checks++; if (res_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_neg_hi: got %h want ffffffff", res_hi); end
    checks++; if (res_lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mul_neg_lo: got %h want fffffff1", res_lo); end
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
    checks++; if (res_lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_quot: got %h want fffffffd", res_lo); end
    checks++; if (res_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_rem: got %h want ffffffff", res_hi); end
  endtask

  task automatic test_divide();
    int lat;
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checks++; if (res_lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_quot: got %h want 80000000", res_lo); end
    checks++; if (res_hi !== 32'h0) begin errors++; $display("FAIL div_ovf_rem: got %h want 0", res_hi); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL div_ovf_flag: got %b want 0", dbz); end
    run_op(2'b10, 32'd100, 32'd7, lat);
    checks++; if (res_lo !== 32'd14) begin errors++; $display("FAIL divu_quot: got %0d want 14", res_lo); end
    checks++; if (res_hi !== 32'd2) begin errors++; $display("FAIL divu_rem: got %0d want 2", res_hi); end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(2'b10, 32'd100, 32'd0, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
    checks++; if (res_lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo: got %h want ffffffff", res_lo); end
    checks++; if (res_hi !== 32'd100) begin errors++; $display("FAIL dz_hi: got %0d want 100", res_hi); end
    checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", dbz); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dz_done_pulse: got %b want 0", done); end
    checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dz_flag_hold: got %b want 1", dbz); end
    run_op(2'b00, 32'd2, 32'd3, lat);
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL dz_flag_clear: got %b want 0", dbz); end
    checks++; if (res_lo !== 32'd6) begin errors++; $display("FAIL after_dz_lo: got %0d want 6", res_lo); end
    checks++; if (res_hi !== 32'd0) begin errors++; $display("FAIL after_dz_hi: got %0d want 0", res_hi); end
  endtask

  task automatic test_back_to_back();
    int lat, lat2;
    @(negedge clk);
    start = 1'b1; op = 2'b00; opa = 32'd7; opb = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin
        start = 1'b1; op = 2'b10; opa = 32'd999; opb = 32'd0;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat != 33) begin errors++; $display("FAIL ignore_latency: got %0d want 33", lat); end
    checks++; if (res_lo !== 32'd42) begin errors++; $display("FAIL ignore_lo: got %0d want 42", res_lo); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL ignore_flag: got %b want 0", dbz); end
    // Start held across the DONE cycle's closing edge.
    start = 1'b1; op = 2'b10; opa = 32'd100; opb = 32'd7;
    lat2 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        start = 1'b0; opa = 32'd5; opb = 32'd1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b want 0", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
      end
      if (done) begin
        lat2 = i;
        break;
      end
    end
    checks++; if (lat2 != 34) begin errors++; $display("FAIL b2b_spacing: got %0d want 34", lat2); end
    checks++; if (res_lo !== 32'd14) begin errors++; $display("FAIL b2b_quot: got %0d want 14", res_lo); end
    checks++; if (res_hi !== 32'd2) begin errors++; $display("FAIL b2b_rem: got %0d want 2", res_hi); end
  endtask

  task automatic test_reset_mid_run();
    int lat, seen;
    @(negedge clk);
    start = 1'b1; op = 2'b01; opa = 32'hFFFF_FFFD; opb = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    checks++; if (res_hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h want 0", res_hi); end
    checks++; if (res_lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h want 0", res_lo); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d active cycles want 0", seen); end
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL rst_after_latency: got %0d want 33", lat); end
    checks++; if (res_lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL rst_after_lo: got %h want fffffff1", res_lo); end
  endtask

  always @(negedge clk) begin
    if (!rst && busy && done) begin
      errors++;
      $display("FAIL busy_done_overlap: busy=%b done=%b want not both", busy, done);
    end
  end

  initial begin
    test_reset();
    test_mulu();
    test_signed();
    test_divide();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
